// File: rtl/reg_bank.sv
// reg_bank - register bank for the image down-sampling processor.
//
// Holds DAR, AC, R and R1-R5. Each one can be loaded from the shared bus,
// incremented, or cleared. AC can also be loaded from the ALU. A store code
// produces a registered byte-write strobe to data memory at address DAR.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   bus_in              shared datapath bus value
//   write_en            destination code: 1 DAR, 2 AC, 3 R, 4-8 R1-R5,
//                       9 data-memory store; all other codes do nothing
//   inc_en, clr_en      increment / clear codes, using the same 1-8 encoding
//   alu_out, alu_we     ALU result and the load strobe for AC
//   dar..r5             register contents
//   z_flag              registered flag, high when AC is zero
//   dm_we/addr/wdata    one-cycle data-memory store (registered)
module reg_bank #(
  parameter int WIDTH = 16,
  parameter int DM_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       write_en,
  input  logic [3:0]       inc_en,
  input  logic [3:0]       clr_en,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_we,
  output logic [WIDTH-1:0] dar,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic             z_flag,
  output logic             dm_we,
  output logic [WIDTH-1:0] dm_addr,
  output logic [DM_W-1:0]  dm_wdata
);

  localparam int NUM_REGS = 8;
  localparam int AC_IDX   = 1;          // slot 0 is DAR, code = slot + 1
  localparam logic [3:0] ST_CODE = 4'd9;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                           z_q;
  logic                           dm_we_q;
  logic [WIDTH-1:0]               dm_addr_q;
  logic [DM_W-1:0]                dm_wdata_q;

  // Per-register next state. Priority: clear > ALU load (AC only) > write > increment.
  // Codes are compared one register at a time, so different registers named
  // by different enables in the same cycle all update on the same edge.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_en == 4'(i + 1))
        regs_d[i] = '0;
      else if (i == AC_IDX && alu_we)
        regs_d[i] = alu_out;
      else if (write_en == 4'(i + 1))
        regs_d[i] = bus_in;
      else if (inc_en == 4'(i + 1))
        regs_d[i] = regs_q[i] + 1'b1;   // wraps modulo 2^WIDTH
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      z_q        <= 1'b1;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
    end else begin
      regs_q  <= regs_d;
      // Computed from the next AC so the flag lines up with the new AC value.
      z_q     <= (regs_d[AC_IDX] == '0);
      dm_we_q <= (write_en == ST_CODE);
      if (write_en == ST_CODE) begin
        // Uses the DAR value from before this edge, so a post-increment
        // of DAR in the same cycle does not move the store address.
        dm_addr_q  <= regs_q[0];
        dm_wdata_q <= bus_in[DM_W-1:0];
      end
    end
  end

  assign dar      = regs_q[0];
  assign ac       = regs_q[1];
  assign r        = regs_q[2];
  assign r1       = regs_q[3];
  assign r2       = regs_q[4];
  assign r3       = regs_q[5];
  assign r4       = regs_q[6];
  assign r5       = regs_q[7];
  assign z_flag   = z_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- General/special-purpose register bank for the image down-sampling processor; sits directly downstream of the shared 16-bit datapath bus.
- Latches the bus value into the register selected by a 4-bit write code, and supports per-register increment and clear.
- Supplies DAR, AC, R and R1–R5 back to the bus mux and ALU.
- Generates the registered data-memory store strobe (byte write at address DAR).

Parameters:
- WIDTH, 16, register and bus width.
- DM_W, 8, data-memory word width (store truncates to this).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- bus_in  input  WIDTH  shared datapath bus value
- write_en  input  4  destination code: 1 DAR, 2 AC, 3 R, 4 R1, 5 R2, 6 R3, 7 R4, 8 R5, 9 data-memory store; 0 and 10–15 no-op
- inc_en  input  4  increment code, same encoding as write_en for 1–8; others no-op
- clr_en  input  4  clear code, same encoding as write_en for 1–8; others no-op
- alu_out  input  WIDTH  ALU result
- alu_we  input  1  load AC from alu_out
- dar, ac, r, r1, r2, r3, r4, r5  output  WIDTH each  register contents
- z_flag  output  1  registered; high when AC is zero
- dm_we  output  1  one-cycle data-memory write strobe
- dm_addr  output  WIDTH  store address
- dm_wdata  output  DM_W  store data

Behaviour:
- Reset (async, rst_n low): all registers 0, dm_we 0, dm_addr 0, dm_wdata 0, z_flag 1. Holds while rst_n is low. Release is sampled at the next rising edge with no extra latency.
- All register updates complete in 1 cycle: a value driven in cycle N is visible on outputs after edge N+1.
- Per-register priority for a single edge: clear > write > increment.
- AC only: alu_we ranks below clr_en but above write_en and inc_en, so AC priority is clear > alu_we > write > increment.
- Different registers targeted by write_en, inc_en and clr_en in the same cycle update independently. Example: write R1, inc DAR and clr R5 all take effect on the same edge.
- Increment is modulo 2^WIDTH; 0xFFFF+1 = 0x0000 with no carry output.
- Registers not targeted hold their value.
- z_flag is registered and equals (next AC == 0), so it is valid in the same cycle the new AC appears.
- Store (write_en == 9), sampled at edge N:
  - dm_we = 1 for exactly the cycle following edge N.
  - dm_addr = DAR value before edge N (pre-increment if inc_en == 1 in the same cycle).
  - dm_wdata = bus_in[DM_W-1:0]; upper bits are discarded.
- Back-to-back stores keep dm_we high continuously, with new addr/data each cycle.
- When no store is sampled: dm_we = 0; dm_addr and dm_wdata hold their last values.
- Codes 0 and 10–15 on any enable are no-ops. Code 10 (instruction memory) is read-only and must never alter state.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive rst_n low mid-cycle after loading R3 = 0x1234 -> all outputs 0 and z_flag = 1 immediately (before the next edge); they stay so until release.
- Write: bus_in = 0xA5C3, write_en = 4 -> r1 = 0xA5C3 after one edge; other registers unchanged. Repeat for codes 1–8 with distinct values; code 10 -> no change.
- Increment wrap: load DAR = 0xFFFF, then inc_en = 1 for two cycles -> dar = 0x0000, then 0x0001.
- Priority: same cycle write_en = 2 (bus 0x0005), alu_we = 1 (alu_out 0x0000), inc_en = 2 -> ac = 0x0000 and z_flag = 1. Next cycle add clr_en = 2 together with alu_we (alu_out 0x0007) -> ac = 0x0000.
- Store: DAR = 0x0040, bus_in = 0x12AB, write_en = 9 with inc_en = 1 -> next cycle dm_we = 1, dm_addr = 0x0040, dm_wdata = 0xAB, dar = 0x0041. Following idle cycle -> dm_we = 0.
- Concurrent targets: write_en = 5 (bus 0x0102), inc_en = 7, clr_en = 8 with R4 = 0x0009, R5 = 0x7777 -> r2 = 0x0102, r4 = 0x000A, r5 = 0x0000.
